// File: rtl/amiga_cas_ctl_if.sv
// Bus bundle between the motherboard glue and the chip-RAM CAS controller.
// Active-low board signals keep an _n suffix; the master side drives CPU/DMA
// inputs, the slave side (the controller) drives CAS, buffer and ROM strobes.
interface amiga_cas_ctl_if #(
    parameter int unsigned BANKS  = 2,
    parameter int unsigned ADDR_W = 24
);
    logic [ADDR_W-1:0] a;
    logic              prw_n;
    logic              uds_n;
    logic              lds_n;
    logic              re_n;
    logic              rgae_n;
    logic              rome_n;
    logic              dae_n;
    logic              arw_n;
    logic              ovl_clr;

    logic [BANKS-1:0]  ucen;
    logic [BANKS-1:0]  lcen;
    logic              rrw_n;
    logic              cdr_n;
    logic              cdw_n;
    logic              rom01_n;
    logic              cack_n;
    logic              busy;

    modport master (
        output a, prw_n, uds_n, lds_n, re_n, rgae_n, rome_n, dae_n, arw_n, ovl_clr,
        input  ucen, lcen, rrw_n, cdr_n, cdw_n, rom01_n, cack_n, busy
    );

    modport slave (
        input  a, prw_n, uds_n, lds_n, re_n, rgae_n, rome_n, dae_n, arw_n, ovl_clr,
        output ucen, lcen, rrw_n, cdr_n, cdw_n, rom01_n, cack_n, busy
    );
endinterface

// File: rtl/amiga_cas_ctl.sv
// Registered chip-RAM CAS / CPU data-buffer controller with DMA-first
// arbitration, plus the Kickstart ROM window decode and its boot overlay.
module amiga_cas_ctl #(
    parameter int unsigned BANKS       = 2,
    parameter int unsigned BANK_LSB    = 20,
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned CAS_CYCLES  = 2,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input logic            clk_i,
    input logic            rst_i,
    amiga_cas_ctl_if.slave bus_io
);
    localparam int unsigned BankW  = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int unsigned MaxCyc = (CAS_CYCLES > HOLD_CYCLES) ? CAS_CYCLES : HOLD_CYCLES;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
    localparam logic [CntW-1:0] CasLast  = CntW'(CAS_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDmaCas,
        StCpuCas,
        StCpuHold,
        StWaitRel
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [BankW-1:0] bank_q, bank_d;
    logic            uds_q, uds_d;   // latched lane enables, active high
    logic            lds_q, lds_d;
    logic            rw_n_q, rw_n_d; // latched _PRW or _ARW of the cycle owner
    logic            ram_q, ram_d;   // 1: RAM cycle, 0: custom-register cycle
    logic            ovl_q, ovl_d;

    logic [BANKS-1:0] ucen_q, ucen_d;
    logic [BANKS-1:0] lcen_q, lcen_d;
    logic            rrw_n_q, rrw_n_d;
    logic            cdr_n_q, cdr_n_d;
    logic            cdw_n_q, cdw_n_d;
    logic            rom01_n_q, rom01_n_d;
    logic            cack_n_q, cack_n_d;
    logic            busy_q, busy_d;

    logic            cpu_req;
    logic            dma_req;
    logic            strb_idle;
    logic [BankW-1:0] bank_sel;
    logic [1:0]      rom_field;
    logic            unused_a;

    assign cpu_req   = (!bus_io.re_n || !bus_io.rgae_n) && (!bus_io.uds_n || !bus_io.lds_n);
    assign dma_req   = !bus_io.dae_n;
    assign strb_idle = bus_io.uds_n && bus_io.lds_n;
    assign rom_field = bus_io.a[20:19];
    assign unused_a  = ^bus_io.a;

    if (BANKS > 1) begin : g_bank_sel
        assign bank_sel = bus_io.a[BANK_LSB +: BankW];
    end else begin : g_single_bank
        assign bank_sel = '0;
    end

    // Cycle sequencing: arbitration in idle, CAS/hold counting, abort and release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        uds_d   = uds_q;
        lds_d   = lds_q;
        rw_n_d  = rw_n_q;
        ram_d   = ram_q;
        unique case (state_q)
            StIdle: begin
                if (dma_req) begin
                    state_d = StDmaCas;
                    bank_d  = bank_sel;
                    uds_d   = 1'b1;
                    lds_d   = 1'b1;
                    rw_n_d  = bus_io.arw_n;
                    ram_d   = 1'b1;
                end else if (cpu_req) begin
                    state_d = StCpuCas;
                    cnt_d   = '0;
                    bank_d  = bank_sel;
                    uds_d   = !bus_io.uds_n;
                    lds_d   = !bus_io.lds_n;
                    rw_n_d  = bus_io.prw_n;
                    ram_d   = !bus_io.re_n;
                end
            end
            StDmaCas: begin
                if (bus_io.dae_n) begin
                    state_d = StIdle;
                end
            end
            StCpuCas: begin
                if (strb_idle) begin
                    state_d = StIdle;
                end else if (cnt_q == CasLast) begin
                    state_d = StCpuHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCpuHold: begin
                // Acknowledge was already given in the last hold clock, so a
                // release seen there completes normally through WAIT_REL.
                if (cnt_q == HoldLast) begin
                    state_d = StWaitRel;
                end else if (strb_idle) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitRel: begin
                if (strb_idle) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs derived from the state being entered and its latched context.
    always_comb begin
        ucen_d   = '0;
        lcen_d   = '0;
        rrw_n_d  = 1'b1;
        cdr_n_d  = 1'b1;
        cdw_n_d  = 1'b1;
        cack_n_d = !(state_d == StCpuHold && cnt_d == HoldLast);
        busy_d   = (state_d != StIdle);
        unique case (state_d)
            StDmaCas: begin
                ucen_d[bank_d] = 1'b1;
                lcen_d[bank_d] = 1'b1;
                rrw_n_d        = rw_n_d;
            end
            StCpuCas: begin
                if (ram_d) begin
                    ucen_d[bank_d] = uds_d;
                    lcen_d[bank_d] = lds_d;
                    rrw_n_d        = rw_n_d;
                end
            end
            default: ;
        endcase
        if (state_d == StCpuCas || state_d == StCpuHold || state_d == StWaitRel) begin
            cdr_n_d = !rw_n_d;
            cdw_n_d = rw_n_d;
        end
    end

    // ROM window decode runs every clock; the overlay maps ROM at the bottom after reset.
    always_comb begin
        ovl_d     = ovl_q & ~bus_io.ovl_clr;
        rom01_n_d = !(!bus_io.rome_n && bus_io.prw_n &&
                      (rom_field == 2'b11 || (ovl_q && rom_field == 2'b00)));
    end

    // State and output registers; reset forces every strobe inactive at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bank_q    <= '0;
            uds_q     <= 1'b0;
            lds_q     <= 1'b0;
            rw_n_q    <= 1'b1;
            ram_q     <= 1'b0;
            ovl_q     <= 1'b1;
            ucen_q    <= '0;
            lcen_q    <= '0;
            rrw_n_q   <= 1'b1;
            cdr_n_q   <= 1'b1;
            cdw_n_q   <= 1'b1;
            rom01_n_q <= 1'b1;
            cack_n_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bank_q    <= bank_d;
            uds_q     <= uds_d;
            lds_q     <= lds_d;
            rw_n_q    <= rw_n_d;
            ram_q     <= ram_d;
            ovl_q     <= ovl_d;
            ucen_q    <= ucen_d;
            lcen_q    <= lcen_d;
            rrw_n_q   <= rrw_n_d;
            cdr_n_q   <= cdr_n_d;
            cdw_n_q   <= cdw_n_d;
            rom01_n_q <= rom01_n_d;
            cack_n_q  <= cack_n_d;
            busy_q    <= busy_d;
        end
    end

    assign bus_io.ucen    = ucen_q;
    assign bus_io.lcen    = lcen_q;
    assign bus_io.rrw_n   = rrw_n_q;
    assign bus_io.cdr_n   = cdr_n_q;
    assign bus_io.cdw_n   = cdw_n_q;
    assign bus_io.rom01_n = rom01_n_q;
    assign bus_io.cack_n  = cack_n_q;
    assign bus_io.busy    = busy_q;
endmodule

// File: tb/tb_amiga_cas_ctl.sv
// Bench for amiga_cas_ctl: directed and randomized CPU, DMA, ROM, abort and
// reset scenarios checked against a cycle-indexed behavioural model.
`timescale 1ns/1ps
module tb_amiga_cas_ctl;
    localparam int unsigned Banks   = 2;
    localparam int unsigned BankLsb = 20;
    localparam int unsigned AddrW   = 24;
    localparam int unsigned CasC    = 2;
    localparam int unsigned HoldC   = 1;
    localparam int unsigned VecW    = 2 * Banks + 5;
    localparam logic [VecW-1:0] IdleVec = {{(2 * Banks){1'b0}}, 5'b11110};

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   ovl_m;

    amiga_cas_ctl_if #(.BANKS(Banks), .ADDR_W(AddrW)) bus ();

    amiga_cas_ctl #(
        .BANKS       (Banks),
        .BANK_LSB    (BankLsb),
        .ADDR_W      (AddrW),
        .CAS_CYCLES  (CasC),
        .HOLD_CYCLES (HoldC)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus_io (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observed {ucen, lcen, _RRW, _CDR, _CDW, _CACK, BUSY}.
    function automatic logic [VecW-1:0] outs();
        return {bus.ucen, bus.lcen, bus.rrw_n, bus.cdr_n, bus.cdw_n, bus.cack_n, bus.busy};
    endfunction

    function automatic int bank_of(input logic [AddrW-1:0] addr);
        return int'(addr / (1 << BankLsb)) % Banks;
    endfunction

    // Expected outputs i clocks after the entry edge of a CPU cycle whose strobes are held.
    function automatic logic [VecW-1:0] cpu_expect(input int i, input int b, input bit u,
                                                   input bit l, input bit wr, input bit ram);
        logic [Banks-1:0] uc;
        logic [Banks-1:0] lc;
        logic rrw;
        logic cack;
        uc   = '0;
        lc   = '0;
        rrw  = 1'b1;
        cack = 1'b1;
        if (i < CasC && ram) begin
            uc[b] = u;
            lc[b] = l;
            rrw   = !wr;
        end
        if (i == CasC + HoldC - 1) cack = 1'b0;
        return {uc, lc, rrw, wr, !wr, cack, 1'b1};
    endfunction

    function automatic logic [VecW-1:0] dma_expect(input int b, input bit arw_n);
        logic [Banks-1:0] m;
        m    = '0;
        m[b] = 1'b1;
        return {m, m, arw_n, 1'b1, 1'b1, 1'b1, 1'b1};
    endfunction

    function automatic logic rom_expect(input logic [AddrW-1:0] addr, input bit rome_n,
                                        input bit prw_n, input bit ovl);
        int f;
        f = int'(addr / (1 << 19)) % 4;
        return !(!rome_n && prw_n && (f == 3 || (ovl && f == 0)));
    endfunction

    task automatic idle_inputs();
        bus.a       = '0;
        bus.prw_n   = 1'b1;
        bus.uds_n   = 1'b1;
        bus.lds_n   = 1'b1;
        bus.re_n    = 1'b1;
        bus.rgae_n  = 1'b1;
        bus.rome_n  = 1'b1;
        bus.dae_n   = 1'b1;
        bus.arw_n   = 1'b1;
        bus.ovl_clr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Runs a full CPU cycle to WAIT_REL, then releases the strobes and checks the return to idle.
    task automatic run_cpu(input logic [AddrW-1:0] addr, input bit u, input bit l,
                           input bit wr, input bit ram, input bit rg_too,
                           input bit scramble, input string tag);
        int b;
        logic [VecW-1:0] e;
        b          = bank_of(addr);
        bus.a      = addr;
        bus.uds_n  = !u;
        bus.lds_n  = !l;
        bus.prw_n  = !wr;
        bus.re_n   = !ram;
        bus.rgae_n = ram ? !rg_too : 1'b0;
        for (int i = 0; i <= int'(CasC + HoldC); i++) begin
            step();
            e = cpu_expect(i, b, u, l, wr, ram);
            n_checks++;
            if (outs() !== e) begin
                n_fail++;
                $display("FAIL %s clk%0d: got %b want %b", tag, i, outs(), e);
            end
            if (scramble) bus.a = AddrW'($urandom);
        end
        bus.uds_n  = 1'b1;
        bus.lds_n  = 1'b1;
        bus.re_n   = 1'b1;
        bus.rgae_n = 1'b1;
        step();
        n_checks++;
        if (outs() !== IdleVec) begin
            n_fail++;
            $display("FAIL %s release: got %b want %b", tag, outs(), IdleVec);
        end
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        bus.rome_n  = 1'b0;
        step();
        step();
        n_checks++;
        if (outs() !== IdleVec) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want %b", outs(), IdleVec);
        end
        n_checks++;
        if (bus.rom01_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rom: got %b want 1", bus.rom01_n);
        end
        bus.rome_n = 1'b1;
        rst_i      = 1'b0;
        ovl_m      = 1'b1;
        step();
        n_checks++;
        if (outs() !== IdleVec) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", outs(), IdleVec);
        end
    endtask

    task automatic rom_random(input int n, input string tag);
        logic e;
        for (int i = 0; i < n; i++) begin
            bus.a      = AddrW'($urandom);
            bus.rome_n = 1'($urandom_range(0, 1));
            bus.prw_n  = 1'($urandom_range(0, 1));
            e          = rom_expect(bus.a, bus.rome_n, bus.prw_n, ovl_m);
            step();
            n_checks++;
            if (bus.rom01_n !== e) begin
                n_fail++;
                $display("FAIL %s #%0d: got %b want %b", tag, i, bus.rom01_n, e);
            end
        end
    endtask

    task automatic test_rom();
        bus.rome_n = 1'b0;
        bus.prw_n  = 1'b1;
        bus.a      = '0;
        step();
        n_checks++;
        if (bus.rom01_n !== 1'b0) begin
            n_fail++;
            $display("FAIL rom_overlay: got %b want 0", bus.rom01_n);
        end
        rom_random(12, "rom_ovl_rand");
        bus.rome_n  = 1'b0;
        bus.prw_n   = 1'b1;
        bus.a       = '0;
        bus.ovl_clr = 1'b1;
        step();
        // Clear takes effect one clock later, so this edge still sees the overlay.
        n_checks++;
        if (bus.rom01_n !== 1'b0) begin
            n_fail++;
            $display("FAIL rom_clr_lag: got %b want 0", bus.rom01_n);
        end
        bus.ovl_clr = 1'b0;
        ovl_m       = 1'b0;
        step();
        n_checks++;
        if (bus.rom01_n !== 1'b1) begin
            n_fail++;
            $display("FAIL rom_cleared_low: got %b want 1", bus.rom01_n);
        end
        bus.a = 24'h180000;
        step();
        n_checks++;
        if (bus.rom01_n !== 1'b0) begin
            n_fail++;
            $display("FAIL rom_high_window: got %b want 0", bus.rom01_n);
        end
        bus.prw_n = 1'b0;
        step();
        n_checks++;
        if (bus.rom01_n !== 1'b1) begin
            n_fail++;
            $display("FAIL rom_write: got %b want 1", bus.rom01_n);
        end
        rom_random(12, "rom_rand");
        idle_inputs();
        step();
    endtask

    task automatic test_dma_vs_cpu(input string tag);
        logic [AddrW-1:0] dma_a;
        logic [AddrW-1:0] cpu_a;
        bit               arw;
        int               hold;
        int unsigned      lanes;
        logic [VecW-1:0]  e;
        dma_a     = AddrW'($urandom);
        cpu_a     = AddrW'($urandom);
        arw       = 1'($urandom_range(0, 1));
        hold      = int'($urandom_range(1, 4));
        lanes     = $urandom_range(1, 3);
        bus.dae_n = 1'b0;
        bus.arw_n = arw;
        bus.a     = dma_a;
        bus.re_n  = 1'b0;
        bus.prw_n = 1'b1;
        bus.uds_n = !lanes[1];
        bus.lds_n = !lanes[0];
        e         = dma_expect(bank_of(dma_a), arw);
        for (int i = 0; i < hold; i++) begin
            step();
            n_checks++;
            if (outs() !== e) begin
                n_fail++;
                $display("FAIL %s dma clk%0d: got %b want %b", tag, i, outs(), e);
            end
            bus.a = AddrW'($urandom);
        end
        bus.dae_n = 1'b1;
        bus.a     = cpu_a;
        step();
        n_checks++;
        if (outs() !== IdleVec) begin
            n_fail++;
            $display("FAIL %s dma_exit: got %b want %b", tag, outs(), IdleVec);
        end
        run_cpu(cpu_a, lanes[1], lanes[0], 1'b0, 1'b1, 1'b0, 1'b0, tag);
    endtask

    task automatic test_abort(input string tag);
        logic [AddrW-1:0] addr;
        int               k;
        int               b;
        logic [VecW-1:0]  e;
        addr       = AddrW'($urandom);
        b          = bank_of(addr);
        k          = int'($urandom_range(0, CasC - 1));
        bus.a      = addr;
        bus.re_n   = 1'b0;
        bus.prw_n  = 1'b0;
        bus.uds_n  = 1'b0;
        bus.lds_n  = 1'b0;
        for (int i = 0; i <= k; i++) begin
            step();
            e = cpu_expect(i, b, 1'b1, 1'b1, 1'b1, 1'b1);
            n_checks++;
            if (outs() !== e) begin
                n_fail++;
                $display("FAIL %s cas clk%0d: got %b want %b", tag, i, outs(), e);
            end
        end
        bus.uds_n = 1'b1;
        bus.lds_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (outs() !== IdleVec) begin
                n_fail++;
                $display("FAIL %s after_abort clk%0d: got %b want %b", tag, i, outs(), IdleVec);
            end
        end
        bus.re_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int unsigned lanes;
        bit          ram;
        for (int n = 0; n < 20; n++) begin
            lanes = $urandom_range(1, 3);
            ram   = ($urandom_range(0, 3) != 0);
            run_cpu(AddrW'($urandom), lanes[1], lanes[0], 1'($urandom_range(0, 1)), ram,
                    1'($urandom_range(0, 1)), 1'b1, "back_to_back");
        end
    endtask

    task automatic test_reset_mid();
        bus.a     = 24'h100000;
        bus.re_n  = 1'b0;
        bus.prw_n = 1'b0;
        bus.uds_n = 1'b0;
        bus.lds_n = 1'b0;
        step();
        step();
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (outs() !== IdleVec) begin
            n_fail++;
            $display("FAIL reset_mid_outs: got %b want %b", outs(), IdleVec);
        end
        idle_inputs();
        step();
        rst_i = 1'b0;
        ovl_m = 1'b1;
        bus.rome_n = 1'b0;
        step();
        n_checks++;
        if (bus.rom01_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sets_ovl: got %b want 0", bus.rom01_n);
        end
        n_checks++;
        if (outs() !== IdleVec) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got %b want %b", outs(), IdleVec);
        end
        bus.rome_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        ovl_m = 1'b1;
        test_reset();
        test_rom();
        run_cpu(24'h100000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "cpu_word_write");
        run_cpu(24'h000002, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "cpu_byte_read");
        run_cpu(24'h100004, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "cpu_re_over_rgae");
        run_cpu(AddrW'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rgae_write");
        for (int i = 0; i < 4; i++) test_dma_vs_cpu("dma_vs_cpu");
        for (int i = 0; i < 4; i++) test_abort("abort");
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
